// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART TX arbitration slice.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BAUD_DIV  = 104;
    localparam int DEF_MAX_BURST = 16;
    localparam int BEAT_W        = $clog2(DEF_MAX_BURST + 1);

    function automatic int ptr_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int beat_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first asserted request strictly after last_ptr wins.
module rr_picker
    import uart_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last_ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(last_ptr) + i) % N);
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one UART TX FIFO among NUM_REQ byte-stream clients,
// plus ownership of the baud divisor and transmitter enable.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BAUD_DIV  = DEF_BAUD_DIV,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0][7:0] req_data_i,
    input  logic [NUM_REQ-1:0]      req_last_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic                    busy_o,
    input  logic                    cfg_we_i,
    input  logic [15:0]             cfg_baud_i,
    output logic                    cfg_pending_o,
    output logic [15:0]             baud_div_o,
    output logic                    tx_we_o,
    output logic [7:0]              din_o,
    output logic                    tx_en_o,
    input  logic                    full_i,
    input  logic                    empty_i
);

    localparam int PTR_W = ptr_w(NUM_REQ);
    localparam int CNT_W = beat_w(MAX_BURST);

    arb_state_e         state, state_next;
    logic [NUM_REQ-1:0] grant_q, winner;
    logic               any_req;
    logic [PTR_W-1:0]   last_ptr, g_idx;
    logic [CNT_W-1:0]   beat_cnt;
    logic [15:0]        shadow_q, baud_q;
    logic               pending_q, tx_en_q;
    logic               g_valid, g_last;
    logic [7:0]         g_data;
    logic               handshake, pkt_end, do_grant, do_apply;

    rr_picker #(.N(NUM_REQ), .PW(PTR_W)) u_picker (
        .req      (req_valid_i),
        .last_ptr (last_ptr),
        .winner   (winner),
        .any      (any_req)
    );

    // Mux out the current owner's stream; grant_q is one-hot or zero.
    always_comb begin
        g_idx   = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx   = PTR_W'(i);
                g_valid = req_valid_i[i];
                g_last  = req_last_i[i];
                g_data  = req_data_i[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_apply   = 1'b0;
        handshake  = 1'b0;
        pkt_end    = 1'b0;
        case (state)
            IDLE: begin
                if (pending_q) begin
                    do_apply = empty_i;
                end else if (any_req) begin
                    do_grant   = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                handshake = g_valid & ~full_i;
                if (handshake && (g_last || beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                    pkt_end    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q  <= '0;
            last_ptr <= PTR_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else if (do_grant) begin
            grant_q  <= winner;
            beat_cnt <= '0;
        end else if (pkt_end) begin
            grant_q  <= '0;
            last_ptr <= g_idx;
        end else if (handshake) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // A write landing in the same cycle as an apply keeps the update pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            baud_q    <= 16'(BAUD_DIV);
            tx_en_q   <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                shadow_q  <= cfg_baud_i;
                pending_q <= 1'b1;
            end else if (do_apply) begin
                pending_q <= 1'b0;
            end
            if (do_apply) baud_q <= shadow_q;
            tx_en_q <= (state == XFER) | ~empty_i;
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = (state == XFER);
    assign req_ready_o   = (state == XFER && !full_i) ? grant_q : '0;
    assign tx_we_o       = handshake;
    assign din_o         = handshake ? g_data : 8'h00;
    assign cfg_pending_o = pending_q;
    assign baud_div_o    = baud_q;
    assign tx_en_o       = tx_en_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int MB = 4;
    localparam int BD = 104;

    logic                clk = 1'b0;
    logic                rstN;
    logic [NR-1:0]       reqValid, reqLast, reqReady, grant;
    logic [NR-1:0][7:0]  reqData;
    logic                busy, cfgWe, cfgPending, txWe, txEn, full, empty;
    logic [15:0]         cfgBaud, baudDiv;
    logic [7:0]          din;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int          mOwner, mLast, mBeats;
    bit          mPending, mTxEn;
    logic [15:0] mShadow, mBaud;
    int          hsCount[NR];

    // stimulus state
    int          rem[NR], seqNo[NR], done[NR];
    bit          autoSpawn, spawnAlways, alwaysValid, randomCtl;
    int          maxLen;
    bit          stimFull, stimEmpty, stimCfgWe;
    logic [15:0] stimCfgBaud;
    logic [3:0]  grantLog[$];
    logic [7:0]  dinLog[$];
    logic [3:0]  nzGrant[$];

    uart_tx_arb #(.NUM_REQ(NR), .BAUD_DIV(BD), .MAX_BURST(MB)) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .req_valid_i   (reqValid),
        .req_data_i    (reqData),
        .req_last_i    (reqLast),
        .req_ready_o   (reqReady),
        .grant_o       (grant),
        .busy_o        (busy),
        .cfg_we_i      (cfgWe),
        .cfg_baud_i    (cfgBaud),
        .cfg_pending_o (cfgPending),
        .baud_div_o    (baudDiv),
        .tx_we_o       (txWe),
        .din_o         (din),
        .tx_en_o       (txEn),
        .full_i        (full),
        .empty_i       (empty)
    );

    always #5 clk = ~clk;

    task automatic resetModel();
        mOwner   = -1;
        mLast    = NR - 1;
        mBeats   = 0;
        mPending = 1'b0;
        mTxEn    = 1'b0;
        mShadow  = '0;
        mBaud    = 16'(BD);
    endtask

    // One packet owner at a time; next owner is the first valid requester after the previous one.
    task automatic stepModel();
        int  pick;
        bit  applied;
        bit  nTxEn;
        applied = 1'b0;
        nTxEn   = (mOwner >= 0) || !empty;
        if (mOwner < 0) begin
            if (mPending) begin
                if (empty) begin
                    mBaud   = mShadow;
                    applied = 1'b1;
                end
            end else begin
                pick = -1;
                for (int k = 1; k <= NR; k++)
                    if (pick < 0 && reqValid[(mLast + k) % NR]) pick = (mLast + k) % NR;
                if (pick >= 0) begin
                    mOwner = pick;
                    mBeats = 0;
                end
            end
        end else if (reqValid[mOwner] && !full) begin
            hsCount[mOwner]++;
            mBeats++;
            if (reqLast[mOwner] || mBeats == MB) begin
                mLast  = mOwner;
                mOwner = -1;
            end
        end
        if (cfgWe) begin
            mShadow  = cfgBaud;
            mPending = 1'b1;
        end else if (applied) begin
            mPending = 1'b0;
        end
        mTxEn = nTxEn;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) hsCount[r] = 0;
        resetModel();
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) resetModel();
            else       stepModel();
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] eGrant, eReady;
        logic [7:0] eDin;
        bit         hs;
        eGrant = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0;
        eReady = (mOwner >= 0 && !full) ? eGrant : 4'b0;
        hs     = 1'b0;
        eDin   = 8'h00;
        if (mOwner >= 0) hs = reqValid[mOwner] && !full;
        if (hs) eDin = reqData[mOwner];
        cmp("grant", 32'(grant), 32'(eGrant));
        cmp("busy", 32'(busy), 32'(mOwner >= 0));
        cmp("ready", 32'(reqReady), 32'(eReady));
        cmp("tx_we", 32'(txWe), 32'(hs));
        cmp("din", 32'(din), 32'(eDin));
        cmp("cfg_pending", 32'(cfgPending), 32'(mPending));
        cmp("baud_div", 32'(baudDiv), 32'(mBaud));
        cmp("tx_en", 32'(txEn), 32'(mTxEn));
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            while (done[r] < hsCount[r]) begin
                done[r]++;
                seqNo[r]++;
                if (rem[r] > 0) rem[r]--;
            end
            if (autoSpawn && rem[r] == 0 && (spawnAlways || $urandom_range(0, 3) == 0))
                rem[r] = $urandom_range(1, maxLen);
            reqValid[r] = (rem[r] > 0) && (alwaysValid || $urandom_range(0, 4) != 0);
            reqData[r]  = {3'(r), 5'(seqNo[r])};
            reqLast[r]  = (rem[r] == 1);
        end
        if (randomCtl) begin
            full    = ($urandom_range(0, 4) == 0);
            empty   = ($urandom_range(0, 9) < 7);
            cfgWe   = ($urandom_range(0, 49) == 0);
            cfgBaud = 16'($urandom);
        end else begin
            full    = stimFull;
            empty   = stimEmpty;
            cfgWe   = stimCfgWe;
            cfgBaud = stimCfgBaud;
        end
        #2;
        checkOutput();
        grantLog.push_back(grant);
        if (grant != 4'b0) nzGrant.push_back(grant);
        if (txWe) dinLog.push_back(din);
    endtask

    task automatic clearStim();
        for (int r = 0; r < NR; r++) begin
            rem[r]   = 0;
            seqNo[r] = 0;
            done[r]  = hsCount[r];
        end
        autoSpawn   = 1'b0;
        spawnAlways = 1'b0;
        alwaysValid = 1'b1;
        randomCtl   = 1'b0;
        maxLen      = 1;
        stimFull    = 1'b0;
        stimEmpty   = 1'b1;
        stimCfgWe   = 1'b0;
        stimCfgBaud = '0;
    endtask

    task automatic doReset();
        #1 rstN = 1'b0;
        clearStim();
        applyStimulus();
        #1 rstN = 1'b1;
        grantLog.delete();
        dinLog.delete();
        nzGrant.delete();
    endtask

    initial begin
        logic [3:0] expG1[9];
        logic [7:0] expD1[6];
        logic [3:0] expRot[6];
        logic [7:0] expBurst[12];

        expG1    = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
        expD1    = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h42};
        expRot   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
        expBurst = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h60, 8'h61,
                     8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};

        rstN = 1'b0;
        reqValid = '0; reqData = '0; reqLast = '0;
        full = 1'b0; empty = 1'b1; cfgWe = 1'b0; cfgBaud = '0;
        for (int r = 0; r < NR; r++) hsCount[r] = 0;
        clearStim();
        applyStimulus();
        applyStimulus();
        cmp("reset_grant", 32'(grant), 32'h0);
        cmp("reset_baud", 32'(baudDiv), 32'd104);
        cmp("reset_pending", 32'(cfgPending), 32'h0);
        cmp("reset_tx_en", 32'(txEn), 32'h0);
        #1 rstN = 1'b1;
        grantLog.delete(); dinLog.delete(); nzGrant.delete();

        $display("[TB] two simultaneous 3-byte packets");
        rem[0] = 3; rem[2] = 3;
        repeat (12) applyStimulus();
        for (int i = 0; i < 9; i++) cmp("pkt_grant_seq", 32'(grantLog[i]), 32'(expG1[i]));
        for (int i = 0; i < 6; i++) cmp("pkt_fifo_bytes", 32'(dinLog[i]), 32'(expD1[i]));

        $display("[TB] continuous 1-byte packets rotate");
        doReset();
        autoSpawn = 1'b1; spawnAlways = 1'b1; maxLen = 1;
        repeat (14) applyStimulus();
        for (int i = 0; i < 6; i++) cmp("rotate_grant", 32'(nzGrant[i]), 32'(expRot[i]));

        $display("[TB] burst limit forces re-arbitration");
        doReset();
        rem[1] = 10; rem[3] = 2;
        repeat (22) applyStimulus();
        for (int i = 0; i < 12; i++) cmp("burst_bytes", 32'(dinLog[i]), 32'(expBurst[i]));

        $display("[TB] back-pressure mid-packet");
        doReset();
        rem[0] = 6;
        repeat (3) applyStimulus();
        stimFull = 1'b1;
        repeat (5) begin
            applyStimulus();
            cmp("full_tx_we", 32'(txWe), 32'h0);
            cmp("full_ready", 32'(reqReady), 32'h0);
        end
        stimFull = 1'b0;
        repeat (8) applyStimulus();
        for (int i = 0; i < 6; i++) cmp("full_bytes", 32'(dinLog[i]), 32'(i));
        cmp("full_byte_count", 32'(dinLog.size()), 32'd6);

        $display("[TB] baud update during transfer");
        doReset();
        rem[0] = 3; rem[1] = 2; stimEmpty = 1'b0;
        applyStimulus();
        stimCfgWe = 1'b1; stimCfgBaud = 16'd52;
        applyStimulus();
        stimCfgWe = 1'b0;
        applyStimulus();
        cmp("cfg_pending_set", 32'(cfgPending), 32'h1);
        repeat (3) applyStimulus();
        cmp("cfg_hold_grant", 32'(grant), 32'h0);
        cmp("cfg_hold_pending", 32'(cfgPending), 32'h1);
        applyStimulus();
        stimEmpty = 1'b1;
        applyStimulus();
        applyStimulus();
        cmp("cfg_baud_applied", 32'(baudDiv), 32'd52);
        cmp("cfg_pending_clear", 32'(cfgPending), 32'h0);
        cmp("cfg_apply_no_grant", 32'(grant), 32'h0);
        applyStimulus();
        cmp("cfg_resume_grant", 32'(grant), 32'h2);
        repeat (4) applyStimulus();

        $display("[TB] asynchronous reset mid-packet");
        rem[2] = 4;
        repeat (3) applyStimulus();
        #1 rstN = 1'b0;
        #1;
        cmp("rst_grant", 32'(grant), 32'h0);
        cmp("rst_busy", 32'(busy), 32'h0);
        cmp("rst_ready", 32'(reqReady), 32'h0);
        cmp("rst_tx_we", 32'(txWe), 32'h0);
        cmp("rst_baud", 32'(baudDiv), 32'd104);
        cmp("rst_tx_en", 32'(txEn), 32'h0);
        clearStim();
        applyStimulus();
        #1 rstN = 1'b1;
        rem[0] = 1; rem[2] = 1;
        applyStimulus();
        applyStimulus();
        cmp("rst_first_grant", 32'(grant), 32'h1);

        $display("[TB] randomized traffic");
        doReset();
        autoSpawn = 1'b1; maxLen = 6; alwaysValid = 1'b0; randomCtl = 1'b1;
        repeat (3000) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
